uart_boot_loader: RTL and testbench

//  Upstream of the single-cycle core: receives a program over a UART line and writes it

---
 rtl/uart_boot_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// Boot loader: receives A5/N/words/CSUM over UART, writes words to instruction ROM, releases the core on a good checksum.
// Latency: ROM strobe one cycle after the 4th byte of each word; core released the cycle after the checksum byte.
// Backpressure: none; the serial line cannot be stalled and each ROM write is an unconditional one-cycle strobe.
module uart_boot_loader #(
   parameter int CLK_HZ      = 50000000,
   parameter int BAUD        = 115200,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_uart_rx,
   output logic              o_rom_we,
   output logic [ADDR_W-1:0] o_rom_addr,
   output logic [31:0]       o_rom_wdata,
   output logic              o_core_enable,
   output logic              o_core_reset,
   output logic              o_busy,
   output logic              o_error
);

   localparam int BIT_CYC = CLK_HZ / BAUD;
   localparam int HALF    = BIT_CYC / 2;
   localparam int CNT_W   = $clog2(BIT_CYC + 1);
   localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(BIT_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);
   localparam logic [7:0]       SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

   // Receiver state
   logic             r_rx_s1, r_rx_s2, r_rx_prev;
   rx_state_t        r_rx_state, w_rx_state_nxt;
   logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
   logic [2:0]       r_rx_bit, w_rx_bit_nxt;
   logic [7:0]       r_rx_shift, w_rx_shift_nxt;
   logic             w_byte_vld, w_stop_err;
   logic [7:0]       w_rx_byte;

   // Protocol state
   state_t           r_state, w_state_nxt;
   logic             w_load_start, w_in_load;
   logic [15:0]      w_n;
   logic [7:0]       r_len_lo;
   logic [16:0]      r_len;
   logic [7:0]       r_csum;
   logic [1:0]       r_byte_idx;
   logic [16:0]      r_word_idx;
   logic [23:0]      r_wbuf;
   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_rom_we;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [31:0]      r_rom_wdata;

   assign w_rx_byte   = r_rx_shift;
   assign o_rom_we    = r_rom_we;
   assign o_rom_addr  = r_rom_addr;
   assign o_rom_wdata = r_rom_wdata;

   // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_s1   <= i_uart_rx;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
      end
   end

   // Receiver state register
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         r_rx_shift <= w_rx_shift_nxt;
      end
   end

   // Receiver sequencing: start re-check at half a bit, then one sample per bit period
   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_cnt_nxt   = r_rx_cnt + CNT_W'(1);
      w_rx_bit_nxt   = r_rx_bit;
      w_rx_shift_nxt = r_rx_shift;
      w_byte_vld     = 1'b0;
      w_stop_err     = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            w_rx_cnt_nxt = '0;
            if (r_rx_prev && !r_rx_s2) w_rx_state_nxt = RX_START;
         end
         RX_START: begin
            if (r_rx_cnt == CNT_HALF) begin
               w_rx_cnt_nxt = '0;
               w_rx_bit_nxt = '0;
               w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (r_rx_cnt == CNT_BIT) begin
               w_rx_cnt_nxt   = '0;
               w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
               if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
               else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
            end
         end
         RX_STOP: begin
            if (r_rx_cnt == CNT_BIT) begin
               w_rx_cnt_nxt   = '0;
               w_rx_state_nxt = RX_IDLE;
               w_byte_vld     = r_rx_s2;
               w_stop_err     = !r_rx_s2;
            end
         end
         default: w_rx_state_nxt = RX_IDLE;
      endcase
   end

   // Protocol state register
   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Protocol next state and status outputs; framing errors and timeouts abort an active load
   always_comb begin
      w_state_nxt  = r_state;
      w_load_start = 1'b0;
      w_in_load    = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                     (r_state == S_DATA) || (r_state == S_CSUM);
      w_n          = {w_rx_byte, r_len_lo};
      case (r_state)
         S_IDLE, S_ERR: begin
            if (w_byte_vld && (w_rx_byte == SYNC_BYTE)) begin
               w_state_nxt  = S_LEN0;
               w_load_start = 1'b1;
            end
         end
         S_LEN0: if (w_byte_vld) w_state_nxt = S_LEN1;
         S_LEN1: begin
            if (w_byte_vld) begin
               if ({1'b0, w_n} > MAX_WORDS) w_state_nxt = S_ERR;
               else if (w_n == 16'd0)       w_state_nxt = S_CSUM;
               else                         w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_byte_vld && (r_byte_idx == 2'd3) && (r_word_idx == r_len - 17'd1))
               w_state_nxt = S_CSUM;
         end
         S_CSUM: if (w_byte_vld) w_state_nxt = (w_rx_byte == r_csum) ? S_RUN : S_ERR;
         S_RUN:  w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_in_load && (w_stop_err || (!w_byte_vld && (r_tmo_cnt == TMO_LAST))))
         w_state_nxt = S_ERR;
      o_busy        = w_in_load;
      o_core_enable = (r_state == S_RUN);
      o_core_reset  = (r_state == S_RUN);
      o_error       = (r_state == S_ERR);
   end

   // Load datapath: length capture, running checksum, word assembly, ROM strobe and idle timer
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_len_lo    <= '0;
         r_len       <= '0;
         r_csum      <= '0;
         r_byte_idx  <= '0;
         r_word_idx  <= '0;
         r_wbuf      <= '0;
         r_tmo_cnt   <= '0;
         r_rom_we    <= 1'b0;
         r_rom_addr  <= '0;
         r_rom_wdata <= '0;
      end else begin
         r_rom_we <= 1'b0;
         if (w_in_load && !w_byte_vld) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
         else                          r_tmo_cnt <= '0;
         if (w_load_start) begin
            r_csum     <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
         end else if (w_byte_vld) begin
            case (r_state)
               S_LEN0: begin
                  r_len_lo <= w_rx_byte;
                  r_csum   <= r_csum ^ w_rx_byte;
               end
               S_LEN1: begin
                  r_len  <= {1'b0, w_rx_byte, r_len_lo};
                  r_csum <= r_csum ^ w_rx_byte;
               end
               S_DATA: begin
                  r_csum     <= r_csum ^ w_rx_byte;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  r_wbuf     <= {w_rx_byte, r_wbuf[23:8]};
                  if (r_byte_idx == 2'd3) begin
                     r_rom_we    <= 1'b1;
                     r_rom_addr  <= r_word_idx[ADDR_W-1:0];
                     r_rom_wdata <= {w_rx_byte, r_wbuf};
                     r_word_idx  <= r_word_idx + 17'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: vector table, hand-written corner sequences and random loads.
// Latency: all checks taken at falling edges, a fixed settle time after the last byte.
// Backpressure: not applicable; the serial driver simply paces bytes at the bit rate.
module tb_uart_boot_loader;
   localparam int CLK_HZ  = 1000000;
   localparam int BAUD    = 100000;
   localparam int ADDR_W  = 4;
   localparam int TMO     = 500;
   localparam int BIT_CYC = CLK_HZ / BAUD;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx = 1'b1;
   logic              o_rom_we;
   logic [ADDR_W-1:0] o_rom_addr;
   logic [31:0]       o_rom_wdata;
   logic              o_core_enable, o_core_reset, o_busy, o_error;

   int checks = 0;
   int failures = 0;
   logic [35:0] wq[$];
   int   we_double = 0;
   logic prev_we = 1'b0;

   typedef struct {
      int               nb;
      logic [0:11][7:0] b;
      int               nw;
      logic [31:0]      w0;
      logic [31:0]      w1;
      bit               run;
      bit               err;
      bit               busy;
   } vec_t;
   vec_t vecs[9];

   always #5 clk = ~clk;

   uart_boot_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_uart_rx(rx),
      .o_rom_we(o_rom_we), .o_rom_addr(o_rom_addr), .o_rom_wdata(o_rom_wdata),
      .o_core_enable(o_core_enable), .o_core_reset(o_core_reset),
      .o_busy(o_busy), .o_error(o_error)
   );

   // ROM write monitor: records every strobe and flags strobes wider than one cycle
   always @(negedge clk) begin
      if (o_rom_we) begin
         wq.push_back({o_rom_addr, o_rom_wdata});
         if (prev_we) we_double++;
      end
      prev_we = o_rom_we;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // 8N1 frame, LSB first; a bad stop bit is followed by an idle bit time
   task automatic send_byte(input logic [7:0] b, input bit good_stop);
      rx = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      rx = good_stop;
      repeat (BIT_CYC) @(negedge clk);
      rx = 1'b1;
      if (!good_stop) repeat (BIT_CYC) @(negedge clk);
   endtask

   task automatic send_vec(input int v);
      for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].b[i], 1'b1);
   endtask

   task automatic check_state(input string tag, input bit run, input bit err, input bit busy);
      chk({tag, ".core_enable"}, o_core_enable, run);
      chk({tag, ".core_reset"},  o_core_reset,  run);
      chk({tag, ".error"},       o_error,       err);
      chk({tag, ".busy"},        o_busy,        busy);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, ".rom_we"},    o_rom_we,    0);
      chk({tag, ".rom_addr"},  o_rom_addr,  0);
      chk({tag, ".rom_wdata"}, o_rom_wdata, 0);
      check_state(tag, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reference load from the bring-up notes: two words, checksum 0x92
      vecs[0] = '{12, {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92},
                  2, 32'h00000013, 32'h00100093, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{12, {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00},
                  2, 32'h00000013, 32'h00100093, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{3, {8'hA5, 8'h11, 8'h00, 72'h0}, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{4, {8'hA5, 8'h00, 8'h00, 8'h00, 64'h0}, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{4, {8'hA5, 8'h00, 8'h00, 8'h5A, 64'h0}, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{3, {8'h12, 8'h34, 8'h56, 72'h0}, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{3, {8'hA5, 8'h10, 8'h00, 72'h0}, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{8, {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23, 32'h0},
                  1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{5, {8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 56'h0}, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};

      // Reset state
      rst_n = 1'b0;
      rx = 1'b1;
      idle(3);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      idle(5);

      // Table-driven vectors, each from a fresh reset
      for (int v = 0; v < 9; v++) begin
         do_reset;
         wq.delete();
         send_vec(v);
         idle(20);
         chk($sformatf("vec%0d.nwrites", v), wq.size(), vecs[v].nw);
         if (vecs[v].nw >= 1 && wq.size() >= 1)
            chk($sformatf("vec%0d.word0", v), wq[0], {4'd0, vecs[v].w0});
         if (vecs[v].nw >= 2 && wq.size() >= 2)
            chk($sformatf("vec%0d.word1", v), wq[1], {4'd1, vecs[v].w1});
         if (vecs[v].nw >= 1)
            chk($sformatf("vec%0d.wdata_hold", v), o_rom_wdata, (vecs[v].nw == 2) ? vecs[v].w1 : vecs[v].w0);
         check_state($sformatf("vec%0d", v), vecs[v].run, vecs[v].err, vecs[v].busy);
      end

      // Bad checksum, then recovery through a fresh sync byte with an empty program
      do_reset;
      wq.delete();
      send_vec(1);
      idle(20);
      check_state("errload", 1'b0, 1'b1, 1'b0);
      wq.delete();
      send_vec(3);
      idle(20);
      chk("recover.nwrites", wq.size(), 0);
      check_state("recover", 1'b1, 1'b0, 1'b0);

      // Inter-byte timeout in DATA: still busy just before the limit, ERR after it
      do_reset;
      wq.delete();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hAA, 1'b1);
      idle(480);
      check_state("tmo_before", 1'b0, 1'b0, 1'b1);
      idle(40);
      check_state("tmo_after", 1'b0, 1'b1, 1'b0);
      chk("tmo.nwrites", wq.size(), 0);

      // Framing error on the length byte
      do_reset;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b0);
      idle(20);
      check_state("badstop", 1'b0, 1'b1, 1'b0);

      // Short low glitch in IDLE must not open a frame that would swallow the next load
      do_reset;
      wq.delete();
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(20);
      check_state("glitch", 1'b0, 1'b0, 1'b0);
      send_vec(0);
      idle(20);
      chk("glitch.nwrites", wq.size(), 2);
      check_state("glitch_load", 1'b1, 1'b0, 1'b0);

      // One-cycle reset in the middle of DATA, after one word has been written
      do_reset;
      wq.delete();
      for (int i = 0; i < 7; i++) send_byte(vecs[0].b[i], 1'b1);
      idle(5);
      chk("middata.nwrites", wq.size(), 1);
      chk("middata.busy", o_busy, 1);
      do_reset;
      check_outputs_zero("midreset");
      wq.delete();
      send_vec(0);
      idle(20);
      chk("reload.nwrites", wq.size(), 2);
      if (wq.size() >= 2) begin
         chk("reload.word0", wq[0], {4'd0, 32'h00000013});
         chk("reload.word1", wq[1], {4'd1, 32'h00100093});
      end
      check_state("reload", 1'b1, 1'b0, 1'b0);

      // Random loads against the protocol model: every word lands at its index; outcome follows the checksum
      for (int it = 0; it < 5; it++) begin
         logic [15:0] n;
         logic [31:0] w [16];
         logic [7:0]  cs;
         bit          bad;
         if (it == 0)      n = 16'd16;
         else if (it == 4) n = 16'($urandom_range(17, 300));
         else              n = 16'($urandom_range(1, 16));
         do_reset;
         wq.delete();
         cs = n[7:0] ^ n[15:8];
         send_byte(8'hA5, 1'b1);
         send_byte(n[7:0], 1'b1);
         send_byte(n[15:8], 1'b1);
         if (n > 16'd16) begin
            idle(20);
            chk($sformatf("rnd%0d.nwrites", it), wq.size(), 0);
            check_state($sformatf("rnd%0d", it), 1'b0, 1'b1, 1'b0);
         end else begin
            for (int k = 0; k < 16; k++) w[k] = $urandom;
            for (int k = 0; k < int'(n); k++) begin
               for (int j = 0; j < 4; j++) begin
                  cs = cs ^ w[k][8*j +: 8];
                  send_byte(w[k][8*j +: 8], 1'b1);
                  idle($urandom_range(0, 25));
               end
            end
            bad = ($urandom_range(0, 2) == 0);
            send_byte(bad ? (cs ^ 8'($urandom_range(1, 255))) : cs, 1'b1);
            idle(20);
            chk($sformatf("rnd%0d.nwrites", it), wq.size(), n);
            for (int k = 0; k < int'(n) && k < wq.size(); k++)
               chk($sformatf("rnd%0d.word%0d", it, k), wq[k], {k[3:0], w[k]});
            check_state($sformatf("rnd%0d", it), !bad, bad, 1'b0);
         end
      end

      chk("rom_we.single_cycle", we_double, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
